// File: rtl/wbuf_alloc_buffer_pkg.sv
// Shared definitions for the allocating write buffer: size limits, the
// response record and an elaboration-time legality check for the depth.
package wbuf_alloc_buffer_pkg;

   localparam int WBUF_ALLOC_DEPTH_MAX = 64;
   localparam int WBUF_ALLOC_DATA_W    = 128;
   localparam int WBUF_ALLOC_BE_W      = WBUF_ALLOC_DATA_W / 8;

   // Default-width read response as seen by crossbar-side consumers.
   typedef struct packed {
      logic [WBUF_ALLOC_DATA_W-1:0] data;
      logic [WBUF_ALLOC_BE_W-1:0]   be;
   } wbuf_alloc_rsp_t;

   function automatic bit wbuf_depth_ok(int depth);
      return (depth >= 2) && (depth <= WBUF_ALLOC_DEPTH_MAX) && ((depth & (depth - 1)) == 0);
   endfunction

endpackage

// File: rtl/wbuf_alloc_buffer_if.sv
// Allocation, write, read/release and status signals of the write buffer.
// master = requester side, slave = buffer side.
interface wbuf_alloc_buffer_if #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 128
);
   localparam int ID_W  = $clog2(DEPTH);
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic              alloc_req;
   logic              alloc_gnt;
   logic [ID_W-1:0]   alloc_id;
   logic              wr_valid;
   logic [ID_W-1:0]   wr_id;
   logic [DATA_W-1:0] wr_data;
   logic [BE_W-1:0]   wr_be;
   logic              rd_valid;
   logic [ID_W-1:0]   rd_id;
   logic              rd_release;
   logic              rd_rsp_valid;
   logic [DATA_W-1:0] rd_rsp_data;
   logic [BE_W-1:0]   rd_rsp_be;
   logic              free_valid;
   logic [ID_W-1:0]   free_id;
   logic [CNT_W-1:0]  count;
   logic              full;
   logic              empty;
   logic              err;

   modport master (
      output alloc_req, wr_valid, wr_id, wr_data, wr_be, rd_valid, rd_id, rd_release,
      input  alloc_gnt, alloc_id, rd_rsp_valid, rd_rsp_data, rd_rsp_be,
             free_valid, free_id, count, full, empty, err
   );

   modport slave (
      input  alloc_req, wr_valid, wr_id, wr_data, wr_be, rd_valid, rd_id, rd_release,
      output alloc_gnt, alloc_id, rd_rsp_valid, rd_rsp_data, rd_rsp_be,
             free_valid, free_id, count, full, empty, err
   );

endinterface

// File: rtl/wbuf_alloc_entry.sv
// One buffer entry: allocation bit, byte-merged data and accumulated byte mask.
// Release beats a same-cycle write so a freed entry never keeps stale enables.
module wbuf_alloc_entry #(
   parameter int DATA_W = 128
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                alloc_set,
   input  logic                release_en,
   input  logic                wr_en,
   input  logic [DATA_W-1:0]   wr_data,
   input  logic [DATA_W/8-1:0] wr_be,
   output logic                alloc,
   output logic [DATA_W-1:0]   data,
   output logic [DATA_W/8-1:0] be
);
   localparam int BE_W = DATA_W / 8;

   logic [DATA_W-1:0] data_q;

   // NOTE: the data storage is reset along with the control bits so an entry
   // leaves reset fully defined; it is a handful of flops, not a RAM macro.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alloc  <= 1'b0;
         be     <= '0;
         data_q <= '0;
      end else if (release_en) begin
         alloc <= 1'b0;
         be    <= '0;
      end else if (alloc_set) begin
         alloc <= 1'b1;
         be    <= '0;
      end else if (wr_en) begin
         // NOTE: non-blocking assignments keep every byte lane reading pre-edge state.
         for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) begin
               data_q[b*8 +: 8] <= wr_data[b*8 +: 8];
               be[b]            <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      // NOTE: default first so every path assigns data and no latch is inferred.
      data = '0;
      for (int b = 0; b < BE_W; b++) begin
         if (be[b]) data[b*8 +: 8] = data_q[b*8 +: 8];
      end
   end

endmodule

// File: rtl/wbuf_alloc_buffer.sv
// Write buffer that owns its free list: grants the lowest free entry, byte-merges
// writes, returns masked read data one cycle later and announces releases.
module wbuf_alloc_buffer
   import wbuf_alloc_buffer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 128
) (
   input  logic               clk,
   input  logic               rst_n,
   wbuf_alloc_buffer_if.slave bus
);
   localparam int ID_W  = $clog2(DEPTH);
   localparam int BE_W  = DATA_W / 8;
   localparam int CNT_W = $clog2(DEPTH + 1);

   if (!wbuf_depth_ok(DEPTH) || (DATA_W % 8) != 0) begin : g_param_check
      $error("wbuf_alloc_buffer: DEPTH must be a power of two in 2..%0d and DATA_W a multiple of 8",
             WBUF_ALLOC_DEPTH_MAX);
   end

   logic [DEPTH-1:0]  alloc_vec;
   logic [DEPTH-1:0]  alloc_set;
   logic [DEPTH-1:0]  wr_sel;
   logic [DEPTH-1:0]  rd_sel;
   logic [DATA_W-1:0] ent_data [DEPTH];
   logic [BE_W-1:0]   ent_be   [DEPTH];
   logic [ID_W-1:0]   low_free;
   logic              alloc_fire;
   logic              release_fire;
   logic              err_d;
   logic [DATA_W-1:0] mux_data;
   logic [BE_W-1:0]   mux_be;

   // Lowest-index free entry wins; scanning downward leaves the lowest hit last.
   always_comb begin
      low_free = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (!alloc_vec[i]) low_free = ID_W'(i);
      end
   end

   assign alloc_fire    = bus.alloc_req & ~(&alloc_vec);
   assign bus.alloc_gnt = alloc_fire;
   assign bus.alloc_id  = low_free;

   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         rd_sel[i]    = (bus.rd_id == ID_W'(i));
         wr_sel[i]    = (bus.wr_id == ID_W'(i));
         alloc_set[i] = alloc_fire && (low_free == ID_W'(i));
      end
   end

   // Decisions use the pre-edge alloc vector, so a released entry is only grantable next cycle.
   assign release_fire = bus.rd_valid & bus.rd_release & alloc_vec[bus.rd_id];
   assign err_d        = (bus.wr_valid & ~alloc_vec[bus.wr_id]) |
                         (bus.rd_valid & ~alloc_vec[bus.rd_id]);

   for (genvar i = 0; i < DEPTH; i++) begin : g_entry
      wbuf_alloc_entry #(.DATA_W(DATA_W)) u_entry (
         .clk        (clk),
         .rst_n      (rst_n),
         .alloc_set  (alloc_set[i]),
         .release_en (release_fire & rd_sel[i]),
         .wr_en      (bus.wr_valid & wr_sel[i] & alloc_vec[i]),
         .wr_data    (bus.wr_data),
         .wr_be      (bus.wr_be),
         .alloc      (alloc_vec[i]),
         .data       (ent_data[i]),
         .be         (ent_be[i])
      );
   end

   // One-hot read mux; free entries present zero data and mask already.
   always_comb begin
      mux_data = '0;
      mux_be   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         mux_data = mux_data | (ent_data[i] & {DATA_W{rd_sel[i]}});
         mux_be   = mux_be   | (ent_be[i]   & {BE_W{rd_sel[i]}});
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.rd_rsp_valid <= 1'b0;
         bus.rd_rsp_data  <= '0;
         bus.rd_rsp_be    <= '0;
         bus.free_valid   <= 1'b0;
         bus.free_id      <= '0;
         bus.count        <= '0;
         bus.err          <= 1'b0;
      end else begin
         bus.rd_rsp_valid <= bus.rd_valid;
         if (bus.rd_valid) begin
            bus.rd_rsp_data <= mux_data;
            bus.rd_rsp_be   <= mux_be;
         end
         bus.free_valid <= release_fire;
         if (release_fire) bus.free_id <= bus.rd_id;
         bus.count <= bus.count + CNT_W'(alloc_fire) - CNT_W'(release_fire);
         bus.err   <= err_d;
      end
   end

   assign bus.full  = (bus.count == CNT_W'(DEPTH));
   assign bus.empty = (bus.count == '0);

endmodule

// File: doc/wbuf_alloc_buffer.md
Name: wbuf_alloc_buffer

Overview:
Parametrised successor to the crossbar-side write buffer. It owns its own free list and hands out entry IDs on request, so requesters no longer supply them. Each entry stores data plus a byte-enable mask, and successive partial writes to one entry are byte-merged. The read-channel side reads with 1-cycle latency and may optionally release the entry. The release generates a registered free notification.

Parameters:
DEPTH, 8, number of entries (power of two, 2..64)
DATA_W, 128, entry data width in bits (multiple of 8)
ID_W, $clog2(DEPTH), entry ID width
BE_W, DATA_W/8, byte-enable width (derived, not overridable)
CNT_W, $clog2(DEPTH+1), occupancy counter width (derived)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_req  in  1  request one entry
alloc_gnt  out  1  combinational grant: alloc_req and at least one free entry
alloc_id  out  ID_W  lowest-index free entry; valid when alloc_gnt
wr_valid  in  1  write strobe
wr_id  in  ID_W  target entry
wr_data  in  DATA_W  write data
wr_be  in  BE_W  byte enables
rd_valid  in  1  read strobe
rd_id  in  ID_W  entry to read
rd_release  in  1  free the entry after this read
rd_rsp_valid  out  1  registered, 1 cycle after rd_valid
rd_rsp_data  out  DATA_W  entry data (masked bytes zero)
rd_rsp_be  out  BE_W  accumulated byte mask
free_valid  out  1  registered release pulse
free_id  out  ID_W  released entry
count  out  CNT_W  allocated entries
full  out  1  count == DEPTH
empty  out  1  count == 0
err  out  1  registered 1-cycle pulse on illegal access

Behaviour:
- Reset (async, rst_n low):
  - all entries free; all data and be registers 0.
  - rd_rsp_valid, rd_rsp_data, rd_rsp_be, free_valid, free_id, count, err are 0.
  - empty=1, full=0.
- Per-entry state: alloc bit, data[DATA_W], be[BE_W].
- Allocation:
  - alloc fire = alloc_req & |free; alloc_id = priority-encode(free), lowest first.
  - On fire: alloc bit set; be cleared to 0 at the same edge.
  - When full: alloc_gnt=0, nothing changes, no err.
- Write to an allocated entry:
  - for each byte b with wr_be[b]=1: data byte b <= wr_data byte b; be[b] <= 1.
  - Other bytes hold.
  - wr_be=0 is a legal no-op.
- Write to an unallocated entry: dropped, err pulses next cycle.
- Read:
  - at edge T, rd_rsp_* is captured from the pre-edge entry state.
  - Output data = data & expand(be).
  - rd_rsp_valid=1 for exactly one cycle.
  - rd_rsp_data and rd_rsp_be hold their values until the next read.
- Read of an unallocated entry: rd_rsp_valid=1, data=0, be=0, err pulse.
- Release (rd_valid & rd_release on an allocated entry):
  - alloc bit cleared and be cleared.
  - free_valid=1 with free_id=rd_id on the next cycle.
  - Release of an unallocated entry: no free_valid, err pulse.
- Occupancy: count <= count + alloc_fire - release_fire. full and empty are decoded from the registered count.
- Simultaneous events:
  - Alloc and release in the same cycle: alloc uses the pre-edge free vector, so the released entry becomes allocatable next cycle. count is unchanged.
  - Write and read of the same id in the same cycle: the read returns pre-write data.
  - Write and release of the same id in the same cycle: release wins. Entry freed, be cleared, no err.
  - Write to an entry being allocated in the same cycle: illegal (entry not yet allocated). Write dropped, err.
  - Multiple err sources in one cycle produce a single err pulse.
- No backpressure on wr or rd; both are accepted every cycle.
- Reset mid-operation: all state and outputs return to reset values immediately; pending responses are lost.

Decomposition:
- mpc_types gains:
  - wbuf_alloc_rsp_t (data, be);
  - localparam WBUF_ALLOC_DEPTH_MAX=64.
- Sub-module wbuf_alloc_entry owns one entry:
  - inputs: alloc_set, release, wr_en, wr_data, wr_be;
  - outputs: alloc, masked data, be.
  - It resolves the release-over-write priority locally.
- The top level holds:
  - the priority encoder;
  - the one-hot read mux (ns_mux1h);
  - the counter and response/free/err registers (ns_gnrl_dfflr).

Test Plan:
1. Reset, then 8 back-to-back alloc_req -> alloc_id 0..7, count=8, full=1. A 9th request gets alloc_gnt=0.
2. Alloc id0, then:
   - write data=0x..AA with be=0x000F;
   - write data=0x..BB00_0000 with be=0x00F0;
   - read id0.
   -> rd_rsp_be=0x00FF, bytes 0-3 from the first write, bytes 4-7 from the second, upper bytes 0.
3. Full buffer; in one cycle alloc_req plus rd_valid with release of id3 -> alloc_gnt=0 that cycle. Next cycle: free_valid=1, free_id=3, count=7; alloc then returns id3.
4. Write to unallocated id5 -> err=1 for one cycle. A subsequent read of id5 -> rd_rsp_valid=1, data=0, be=0, err=1.
5. Same cycle: write 0xFF..FF with be=all to id2, plus read with release of id2 -> rd_rsp shows the old data. Entry is freed and be cleared. Realloc then read -> be=0.
6. Assert rst_n low mid-read with count=4 -> rd_rsp_valid, free_valid, err and count are 0 immediately. After reset, alloc returns id0.
